cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Shared main-memory arbiter between the instruction-cache and data-cache miss handlers. Accepts one outstanding request from each cache controller, grants one at a time to the single main-memory port, waits for the memory to complete, and returns the read data with a one-cycle done pulse. Grants favour the D-cache, with a streak limit that prevents I-cache starvation. A watchdog flags memory transactions that never complete.

## Interface
- `AW`, 16: address width.
- `DW`, 16: data width.
- `MAX_D_STREAK`, 4: maximum consecutive D grants while an I request waits.
- `TIMEOUT`, 64: cycles in WAIT before `err` fires.
- `clk` in 1: single clock. All logic is clocked on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_req` in 1: I-cache request. Held high until `i_done`.
- `i_addr` in AW: I-cache word address.
- `d_req` in 1: D-cache request. Held high until `d_done`.
- `d_wr` in 1: D-cache request is a write.
- `d_addr` in AW: D-cache word address.
- `d_wdata` in DW: D-cache write data.
- `i_done` out 1: one-cycle completion pulse to the I-cache.
- `d_done` out 1: one-cycle completion pulse to the D-cache.
- `rdata` out DW: registered read data. Valid only while a done pulse is high.
- `mem_en` out 1: one-cycle memory start strobe.
- `mem_wr` out 1: write qualifier for `mem_en`.
- `mem_addr` out AW: registered memory address.
- `mem_wdata` out DW: registered memory write data.
- `mem_done` in 1: memory completion. Asserts at least 1 cycle after `mem_en`.
- `mem_rdata` in DW: memory read data. Valid only with `mem_done`.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle pulse on timeout.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP. Reset enters IDLE.
- **IDLE**
  - No request pending: remain in IDLE.
  - At least one request pending: latch the winner (`owner`), its address, its write flag and its write data into the `mem_*` registers, then go to ISSUE.
  - The I-cache is always a read, so `mem_wr` = 0 for I grants.
- **Arbitration**
  - Only `d_req`: D wins. Only `i_req`: I wins.
  - Both pending: D wins unless `streak` == MAX_D_STREAK, in which case I wins.
- **streak counter**
  - Width is $clog2(MAX_D_STREAK+1).
  - Increments when D is granted while `i_req` is high.
  - Clears when I is granted.
  - Clears when D is granted with `i_req` low.
  - Never exceeds MAX_D_STREAK.
- **ISSUE**: `mem_en` = 1 for exactly this cycle. Go to WAIT. Clear the timeout counter.
- **WAIT**
  - On `mem_done`: register `mem_rdata` into `rdata` (read or write alike), then go to RESP.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 without `mem_done`: pulse `err` next cycle, return to IDLE, issue no done.
  - `mem_done` outside WAIT is ignored.
- **RESP**: assert the owner's done for one cycle, then go to IDLE.
  - The requester must drop its `req` in the cycle following done.
  - A `req` still high in that IDLE cycle is treated as a new request.
- Requests arriving while `busy` are not lost. They are sampled again at the next IDLE.
- `d_wr`, `d_addr` and `d_wdata` are sampled only in IDLE. Changes while `busy` have no effect.

## Timing
- Reset (asynchronous, `rst` = 0) forces these immediately:
  - state = IDLE
  - `streak` = 0, timeout counter = 0
  - `i_done` = `d_done` = 0
  - `rdata` = 0
  - `mem_en` = `mem_wr` = 0, `mem_addr` = 0, `mem_wdata` = 0
  - `busy` = 0, `err` = 0
- Reset mid-transaction abandons it. No done is issued, and the memory response is ignored after release.
- All outputs are registered. There are no combinational input-to-output paths.
- **Latency**
  - Request seen in IDLE at cycle 0.
  - `mem_en` high in cycle 1.
  - If `mem_done` arrives in cycle 1+L (L ≥ 1), done is high in cycle 2+L.
  - Minimum request-to-done latency is 3 cycles (L = 1).
- Back-to-back requests: next `mem_en` comes no earlier than 2 cycles after the previous done. Throughput is one transaction per L+3 cycles.
- Timeout: `err` pulses in cycle 1+TIMEOUT+1 after ISSUE, and `busy` drops the same cycle.

## Test plan
- **Reset values**: hold `rst` = 0 with random inputs -> all outputs 0. Release with no requests -> `busy` stays 0.
- **Single I read**: `i_addr` = 0x0040, memory L = 2 returning 0xBEEF -> `mem_en` in cycle 1 with `mem_addr` 0x0040 and `mem_wr` 0; `i_done` in cycle 4 with `rdata` 0xBEEF; `d_done` never high.
- **Single D write**: `d_addr` = 0x1234, `d_wdata` = 0xA5A5, L = 1 -> `mem_wr` 1, `mem_wdata` 0xA5A5, `d_done` in cycle 3.
- **Contention and streak**: `i_req` held high, D re-requests immediately after every done, MAX_D_STREAK = 4 -> grant order D, D, D, D, I. Then D, D, D, D, I again.
- **Simultaneous first request**: both requests rise in the same cycle with `streak` = 0 -> D is served first, then I. Each receives exactly one done with its own data.
- **Timeout and recovery**:
  - `mem_done` never asserted, TIMEOUT = 64 -> one `err` pulse, no done, return to IDLE.
  - A following request with L = 1 completes normally.
  - Assert `rst` low during WAIT -> no done after release.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Shared main-memory arbiter for I-cache and D-cache miss handlers.
// D-cache is favoured; a streak limit guarantees forward progress for the I-cache.
module cache_mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          i_done,
  output logic          d_done,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_done,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          err
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;     // 1: D-cache owns the transaction
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          d_win;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    d_win       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // D wins unless the I-cache has watched MAX_D_STREAK D grants in a row
          d_win    = d_req && !(i_req && (streak_q == SW'(MAX_D_STREAK)));
          owner_d  = d_win;
          mem_en_d = 1'b1;
          state_d  = ISSUE;
          if (d_win) begin
            mem_addr_d  = d_addr;
            mem_wr_d    = d_wr;
            mem_wdata_d = d_wdata;
            streak_d    = i_req ? streak_q + SW'(1) : '0;
          end else begin
            mem_addr_d  = i_addr;
            mem_wr_d    = 1'b0;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_done) begin
          rdata_d  = mem_rdata;
          i_done_d = !owner_q;
          d_done_d = owner_q;
          state_d  = RESP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      streak_q    <= '0;
      tmo_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model (grant rule, streak count, memory image).
module tb_cache_mem_arbiter;

  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int MAX_D   = 4;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_wr, mem_done;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          i_done, d_done, mem_en, mem_wr, busy, err;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;
  int streak_m = 0;
  logic [DW-1:0] mem_m [logic [AW-1:0]];

  cache_mem_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAX_D), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_done(i_done), .d_done(d_done), .rdata(rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mval(input logic [AW-1:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 16'hC3C3;
  endfunction

  // One IDLE cycle after a done/err: nothing may be active.
  task automatic idle(input string tag);
    tick;
    chk(tag, {busy, mem_en, i_done, d_done, err}, 64'd0);
  endtask

  // Precondition: DUT is in IDLE and the next edge samples the current requests.
  // L = 0 means the memory never answers.
  task automatic txn(input int L, input string tag, output bit obs_d);
    bit exp_d, w, bad;
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    exp_d = d_req && !(i_req && streak_m == MAX_D);
    if (exp_d) begin
      a = d_addr; w = d_wr;
      if (w) mem_m[a] = d_wdata;
      streak_m = i_req ? streak_m + 1 : 0;
    end else begin
      a = i_addr; w = 1'b0;
      streak_m = 0;
    end
    v = mval(a);
    tick;
    chk({tag, ".issue"}, {mem_en, busy, mem_wr, mem_addr}, {1'b1, 1'b1, w, a});
    if (w) chk({tag, ".wdata"}, mem_wdata, v);
    bad = 1'b0;
    obs_d = 1'b0;
    if (L == 0) begin
      for (int c = 2; c <= TIMEOUT + 1; c++) begin
        tick;
        mem_rdata = 16'($urandom);
        bad |= ({mem_en, i_done, d_done, err, busy} !== 5'b00001);
      end
      chk({tag, ".quiet"}, bad, 0);
      tick;
      chk({tag, ".err"}, {err, busy, i_done, d_done}, 4'b1000);
    end else begin
      for (int c = 1; c <= L; c++) begin
        tick;
        bad |= ({mem_en, i_done, d_done, err, busy} !== 5'b00001);
        if (c == L) begin mem_done = 1'b1; mem_rdata = v; end
        else mem_rdata = 16'($urandom);
      end
      chk({tag, ".quiet"}, bad, 0);
      tick;
      mem_done = 1'b0;
      mem_rdata = 16'($urandom);
      chk({tag, ".done"}, {i_done, d_done, rdata, busy, err}, {~exp_d, exp_d, v, 1'b1, 1'b0});
      obs_d = d_done;
    end
  endtask

  task automatic new_i;
    i_req  = 1'($urandom_range(0, 1));
    i_addr = 16'($urandom_range(0, 15));
  endtask

  task automatic new_d;
    d_req   = 1'($urandom_range(0, 1));
    d_addr  = 16'($urandom_range(0, 15));
    d_wr    = 1'($urandom_range(0, 1));
    d_wdata = 16'($urandom);
  endtask

  initial begin
    bit o, o1, o2;
    logic [9:0] pat;

    // Reset with random inputs: every output forced low.
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_req = 1'($urandom); d_req = 1'($urandom); d_wr = 1'($urandom);
      i_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      mem_done = 1'($urandom); mem_rdata = 16'($urandom);
      tick;
      chk("reset_outs", {i_done, d_done, rdata, mem_en, mem_wr, mem_addr, mem_wdata, busy, err}, 64'd0);
    end
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; mem_done = 1'b0;
    tick;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) idle("release_idle");

    // Single I read.
    mem_m[16'h0040] = 16'hBEEF;
    i_addr = 16'h0040; i_req = 1'b1;
    txn(2, "i_read", o);
    idle("i_read_gap");
    i_req = 1'b0;

    // Single D write.
    d_addr = 16'h1234; d_wdata = 16'hA5A5; d_wr = 1'b1; d_req = 1'b1;
    txn(1, "d_write", o);
    idle("d_write_gap");
    d_req = 1'b0; d_wr = 1'b0;

    // Contention: both held high, D re-requests straight after each done.
    i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0100; d_addr = 16'h0200;
    pat = '0;
    for (int k = 0; k < 10; k++) begin
      txn(int'($urandom_range(1, 3)), "contend", o);
      pat = {pat[8:0], o};
      idle("contend_gap");
      d_addr = d_addr + 16'd1;
      if (!o) i_addr = i_addr + 16'd1;
    end
    chk("streak_order", pat, 10'b1111011110);
    i_req = 1'b0; d_req = 1'b0;
    idle("contend_end");

    // Simultaneous first request with streak at zero.
    mem_m[16'h0300] = 16'h1111; mem_m[16'h0301] = 16'h2222;
    i_addr = 16'h0300; d_addr = 16'h0301; i_req = 1'b1; d_req = 1'b1;
    txn(1, "simul_1", o1);
    idle("simul_gap");
    d_req = 1'b0;
    txn(2, "simul_2", o2);
    idle("simul_end");
    i_req = 1'b0;
    chk("simul_order", {o1, o2}, 2'b10);

    // Timeout, then recovery.
    i_addr = 16'h0005; i_req = 1'b1;
    txn(0, "timeout", o);
    i_req = 1'b0;
    idle("post_err");
    d_addr = 16'h0007; d_wr = 1'b0; d_req = 1'b1;
    txn(1, "recover", o);
    idle("recover_gap");
    d_req = 1'b0;

    // Reset while waiting on memory abandons the transaction.
    i_addr = 16'h0009; i_req = 1'b1;
    tick; tick; tick;
    rst = 1'b0;
    #1;
    chk("mid_reset", {i_done, d_done, rdata, mem_en, mem_wr, mem_addr, mem_wdata, busy, err}, 64'd0);
    i_req = 1'b0; mem_done = 1'b1; mem_rdata = 16'hDEAD;
    tick;
    rst = 1'b1;
    tick;
    mem_done = 1'b0;
    streak_m = 0;
    for (int k = 0; k < 4; k++) idle("post_reset");
    chk("post_reset_rdata", rdata, 16'd0);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      if (!i_req && !d_req) begin new_i; new_d; end
      if (!i_req && !d_req) begin
        idle("rnd_idle");
        continue;
      end
      txn(int'($urandom_range(1, 4)), "rnd", o);
      idle("rnd_gap");
      if (o) begin
        new_d;
        if (!i_req) new_i;
      end else begin
        new_i;
        if (!d_req) new_d;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
